gate_pool_arbiter: RTL

GATE_POOL_ARBITER -- requirements
Module: gate_pool_arbiter

---
 rtl/gate_pool_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gate_pool_arbiter.sv
// Round-robin arbiter in front of a shared bitwise logic unit (NOT/OR/AND).
// One transaction at a time: IDLE grants, EXEC computes, RESP holds until consumed.
`timescale 1ns/1ps
module gate_pool_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  localparam int ID_W = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [2*N_REQ-1:0]     i_op,
  input  logic [WIDTH*N_REQ-1:0] i_a,
  input  logic [WIDTH*N_REQ-1:0] i_b,
  input  logic                   i_ready,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [WIDTH-1:0]       o_result,
  output logic [ID_W-1:0]        o_id,
  output logic                   o_valid,
  output logic                   o_err,
  output logic                   o_busy,
  output logic [15:0]            o_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  next_ptr;
  int               idx;

  // Search upward from ptr, wrapping at N_REQ; the first set request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && i_req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    next_ptr = '0;
    if (winner != ID_W'(N_REQ - 1)) next_ptr = winner + 1'b1;
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      o_gnt    <= '0;
      o_result <= '0;
      o_id     <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_gnt <= '0;
          if (found) begin
            state <= EXEC;
            ptr   <= next_ptr;
            op_q  <= i_op[int'(winner)*2 +: 2];
            a_q   <= i_a[int'(winner)*WIDTH +: WIDTH];
            b_q   <= i_b[int'(winner)*WIDTH +: WIDTH];
            o_id  <= winner;
            o_gnt <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
          end
        end
        EXEC: begin
          state   <= RESP;
          o_gnt   <= '0;
          o_valid <= 1'b1;
          o_err   <= 1'b0;
          case (op_q)
            2'b00: o_result <= ~a_q;
            2'b01: o_result <= a_q | b_q;
            2'b10: o_result <= a_q & b_q;
            2'b11: begin
              o_result <= '0;
              o_err    <= 1'b1;
            end
          endcase
        end
        RESP: begin
          o_gnt <= '0;
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (o_count != 16'hFFFF) o_count <= o_count + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          o_gnt   <= '0;
          o_valid <= 1'b0;
          o_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
